// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan controller: 16 row pairs x 64 columns with binary-coded modulation
// over D bit planes and a double-buffer flip that only happens between frames.
module hub75_scan_ctrl #(
   parameter int BITS_PER_PIXEL = 6,
   parameter int BASE_TICKS     = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   output logic [9:0]                read_addr,
   output logic                      read_en,
   input  logic [BITS_PER_PIXEL-1:0] read_data_top,
   input  logic [BITS_PER_PIXEL-1:0] read_data_bottom,
   output logic                      buffer_toggle,
   input  logic                      swap_req,
   output logic                      swap_ack,
   output logic                      frame_sync,
   output logic [2:0]                rgb_top,
   output logic [2:0]                rgb_bottom,
   output logic                      hub75_clk,
   output logic                      hub75_lat,
   output logic                      hub75_oe_n,
   output logic [3:0]                hub75_addr
);
   localparam int D  = BITS_PER_PIXEL / 3;
   localparam int PW = (D > 1) ? $clog2(D) : 1;
   localparam int TW = $clog2(BASE_TICKS << (D - 1)) + 1;
   localparam logic [7:0] LAST_STEP = 8'd128;

   typedef enum logic [1:0] {S_SHIFT, S_BLANK, S_LATCH, S_DISPLAY} state_t;

   state_t        state, state_nx;
   logic          run;
   logic [7:0]    step, step_nx;
   logic [3:0]    row, row_nx;
   logic [PW-1:0] plane, plane_nx;
   logic [TW-1:0] tick, tick_nx;
   logic [TW-1:0] disp_len;
   logic          last_plane, disp_done, frame_end, shift_load;
   logic [5:0]    fetch_col;
   logic [2:0]    sel_top, sel_bottom, hold_top, hold_bottom;

   // Plane bit of each colour channel, straight from the RAM word.
   for (genvar ch = 0; ch < 3; ch++) begin : g_ch
      logic [D-1:0] top_bits, bottom_bits;
      assign top_bits       = read_data_top[ch*D +: D];
      assign bottom_bits    = read_data_bottom[ch*D +: D];
      assign sel_top[ch]    = top_bits[plane];
      assign sel_bottom[ch] = bottom_bits[plane];
   end

   always_comb begin
      state_nx   = state;
      step_nx    = step;
      row_nx     = row;
      plane_nx   = plane;
      tick_nx    = tick;
      disp_len   = TW'(BASE_TICKS) << plane;
      last_plane = (plane == PW'(D - 1));
      disp_done  = (state == S_DISPLAY) && (tick == disp_len - TW'(1));
      frame_end  = run && disp_done && last_plane && (row == 4'd15);

      // run is low for the single cycle after reset so the first released
      // edge lands on SHIFT step 0 instead of skipping past it.
      if (run) begin
         unique case (state)
            S_SHIFT: begin
               if (step == LAST_STEP) begin
                  state_nx = S_BLANK;
                  step_nx  = '0;
               end else begin
                  step_nx = step + 8'd1;
               end
            end
            S_BLANK: state_nx = S_LATCH;
            S_LATCH: begin
               state_nx = S_DISPLAY;
               tick_nx  = '0;
            end
            S_DISPLAY: begin
               if (disp_done) begin
                  state_nx = S_SHIFT;
                  tick_nx  = '0;
                  if (last_plane) begin
                     plane_nx = '0;
                     row_nx   = row + 4'd1;
                  end else begin
                     plane_nx = plane + PW'(1);
                  end
               end else begin
                  tick_nx = tick + TW'(1);
               end
            end
         endcase
      end

      // Odd steps present column (step-1)/2; even steps >0 raise the panel clock.
      fetch_col  = step[7] ? 6'd63 : step[6:1];
      read_en    = run && (state == S_SHIFT);
      read_addr  = read_en ? {row, fetch_col} : 10'd0;
      shift_load = read_en && step[0];
      hub75_clk  = read_en && (step != 8'd0) && !step[0];
      hub75_lat  = run && (state == S_LATCH);
      hub75_oe_n = !(run && (state == S_DISPLAY));
      frame_sync = read_en && (step == 8'd0) && (row == 4'd0) && (plane == '0);
      rgb_top    = shift_load ? sel_top : hold_top;
      rgb_bottom = shift_load ? sel_bottom : hold_bottom;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= S_SHIFT;
         step  <= '0;
         row   <= '0;
         plane <= '0;
         tick  <= '0;
         run   <= 1'b0;
      end else begin
         state <= state_nx;
         step  <= step_nx;
         row   <= row_nx;
         plane <= plane_nx;
         tick  <= tick_nx;
         run   <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         buffer_toggle <= 1'b0;
         swap_ack      <= 1'b0;
         hub75_addr    <= 4'd0;
         hold_top      <= 3'd0;
         hold_bottom   <= 3'd0;
      end else begin
         swap_ack <= frame_end && swap_req;
         if (frame_end && swap_req)
            buffer_toggle <= ~buffer_toggle;
         // Row select moves on the edge into BLANK, while the panel is dark.
         if (read_en && (step == LAST_STEP))
            hub75_addr <= row;
         if (shift_load) begin
            hold_top    <= sel_top;
            hold_bottom <= sel_bottom;
         end
      end
   end
endmodule

// File: doc/hub75_scan_ctrl.md
HUB75_SCAN_CTRL -- requirements
Module: hub75_scan_ctrl

Interface
REQ-001 Parameter BITS_PER_PIXEL, default 6, pixel word width; per-channel depth D = BITS_PER_PIXEL/3; pixel layout R=[D-1:0], G=[2D-1:D], B=[3D-1:2D].
REQ-002 Parameter BASE_TICKS, default 4, display clocks for bit plane 0.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 reset_n  in  1  reset, synchronous, active-low.
REQ-005 read_addr  out  10  pixel RAM read address {row[3:0], col[5:0]}.
REQ-006 read_en  out  1  pixel RAM read enable.
REQ-007 read_data_top  in  BITS_PER_PIXEL  RAM data, upper half-panel, valid 1 clk after read_en/read_addr.
REQ-008 read_data_bottom  in  BITS_PER_PIXEL  RAM data, lower half-panel, same timing.
REQ-009 buffer_toggle  out  1  selects write buffer; display reads the other buffer.
REQ-010 swap_req  in  1  writer requests buffer flip; level, held until swap_ack.
REQ-011 swap_ack  out  1  one-clk pulse, flip performed.
REQ-012 frame_sync  out  1  one-clk pulse at start of each frame (row 0, plane 0, first SHIFT cycle).
REQ-013 rgb_top  out  3  {B,G,R} panel bits, upper half.
REQ-014 rgb_bottom  out  3  {B,G,R} panel bits, lower half.
REQ-015 hub75_clk  out  1  panel shift clock; panel samples on rising edge.
REQ-016 hub75_lat  out  1  panel latch.
REQ-017 hub75_oe_n  out  1  panel output enable, active-low.
REQ-018 hub75_addr  out  4  panel row select.

Function
REQ-019 Scan order: for row 0..15, for plane 0..D-1: SHIFT -> BLANK -> LATCH -> DISPLAY; frame = 16*D such sequences.
REQ-020 SHIFT lasts 129 clks: clk 0 issues read of col 0 only; clk k (1..128) issues read of col k/2 on even k <= 126 and shifts col (k-1)/2 on odd/even pair.
REQ-021 SHIFT per column c: first clk rgb_* = plane bit of RAM data for col c, hub75_clk=0; second clk rgb_* held, hub75_clk=1; exactly 64 rising edges per SHIFT.
REQ-022 read_en SHALL be 1 throughout SHIFT and 0 in all other states; read_addr = {current row, column being fetched}.
REQ-023 rgb_top[0]=read_data_top[plane], [1]=read_data_top[D+plane], [2]=read_data_top[2D+plane]; rgb_bottom likewise from read_data_bottom.
REQ-024 hub75_oe_n SHALL be 1 in SHIFT, BLANK, LATCH.
REQ-025 BLANK: 1 clk, hub75_clk=0, hub75_addr updated to current row.
REQ-026 LATCH: 1 clk, hub75_lat=1; hub75_lat=0 in every other state.
REQ-027 DISPLAY: hub75_oe_n=0 for exactly BASE_TICKS << plane clks, then plane++; on plane D-1 wrap plane to 0 and row++; row 15 wraps to 0 (frame end).
REQ-028 hub75_addr SHALL change only in BLANK; never while hub75_oe_n=0.
REQ-029 At frame end (last DISPLAY clk of row 15, plane D-1) with swap_req=1: buffer_toggle inverts and swap_ack pulses on next clk; flip never occurs mid-frame.
REQ-030 swap_req=0 at frame end: no flip, no ack; swap_req asserted mid-frame is serviced at next frame end only.
REQ-031 swap_ack SHALL not re-pulse while swap_req stays high until at least one further frame end.
REQ-032 Display timing SHALL be independent of swap_req (no stalls).

Reset
REQ-033 reset_n=0 sampled on clk edge: state=SHIFT clk 0, row=0, plane=0, buffer_toggle=0, swap_ack=0, frame_sync=0, read_en=0, read_addr=0, rgb_*=0, hub75_clk=0, hub75_lat=0, hub75_oe_n=1, hub75_addr=0.
REQ-034 Reset asserted mid-operation SHALL abort current sequence within the same edge; pending swap_req is discarded.
REQ-035 First clk after reset release SHALL be frame start with frame_sync=1.

Verification (D=2, BASE_TICKS=4)
REQ-036 Release reset, RAM returns top=6'b000001 all cols -> 64 hub75_clk rising edges with rgb_top=3'b001 in plane 0, 3'b000 in plane 1; hub75_lat pulse 1 clk after BLANK.
REQ-037 Count frame cycles -> frame_sync period 4384 clks; DISPLAY low-time 4 clks (plane 0), 8 clks (plane 1); row period 274 clks.
REQ-038 Assert swap_req at row 5 -> buffer_toggle flips 0->1 only at frame end, swap_ack single pulse, frame_sync pulse immediately follows.
REQ-039 Monitor hub75_addr and hub75_oe_n whole frame -> addr changes only while oe_n=1, sequence 0..15 then 0.
REQ-040 Assert reset_n=0 during DISPLAY of row 9 -> next clk oe_n=1, addr=0, read_en=0; after release frame restarts at row 0 plane 0.
